// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port indices,
// default segment base and the address-check rule.
package data_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned ADDR_W            = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // An address is bad when it is not word aligned or its word offset from
  // the segment base falls outside the memory. Addresses below the base wrap
  // to huge offsets, so they fail the range test without a separate compare.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input int unsigned       depth);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (addr[1:0] != 2'b00) || ({2'b00, offset[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_addr_range_check.sv
// Combinational alignment/range check of one byte address against the data
// segment.
module data_mem_arbiter_addr_range_check
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0]  BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic                  err_o
);

  assign err_o = addr_fault(ADDR_W'(addr_i), ADDR_W'(BASE_ADDR), MEMORY_DEPTH);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port 0 is the
// core data path, port 1 the loader/DMA engine. Round-robin arbitration with
// a bounded burst lock for port 1, address checking, and a one-cycle
// registered response per port.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned           MAX_LOCK     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  P0_Valid_i,
  input  logic                  P0_We_i,
  input  logic [DATA_WIDTH-1:0] P0_Address_i,
  input  logic [DATA_WIDTH-1:0] P0_Write_Data_i,
  output logic                  P0_Ready_o,
  output logic                  P0_Resp_Valid_o,
  output logic [DATA_WIDTH-1:0] P0_Read_Data_o,
  output logic                  P0_Err_o,
  input  logic                  P1_Valid_i,
  input  logic                  P1_We_i,
  input  logic [DATA_WIDTH-1:0] P1_Address_i,
  input  logic [DATA_WIDTH-1:0] P1_Write_Data_i,
  input  logic                  P1_Lock_i,
  output logic                  P1_Ready_o,
  output logic                  P1_Resp_Valid_o,
  output logic [DATA_WIDTH-1:0] P1_Read_Data_o,
  output logic                  P1_Err_o,
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   last_grant_q;

  logic                   gnt_p0, gnt_p1, accept;
  logic                   sel_we;
  logic [DATA_WIDTH-1:0]  sel_addr, sel_wdata;
  logic                   sel_err;
  logic [DATA_WIDTH-1:0]  rdata_d;

  logic [1:0]             resp_vld_q;
  logic [1:0]             err_q;
  logic [DATA_WIDTH-1:0]  rdata0_q, rdata1_q;

  // Grant selection; nothing is accepted while reset is held.
  always_comb begin
    gnt_p0 = 1'b0;
    gnt_p1 = 1'b0;
    if (!reset) begin
      if (P0_Valid_i && P1_Valid_i) begin
        if (state_q == ST_LOCKED)   gnt_p1 = 1'b1;
        else if (last_grant_q == P1) gnt_p0 = 1'b1;
        else                         gnt_p1 = 1'b1;
      end else if (P0_Valid_i) begin
        gnt_p0 = 1'b1;
      end else if (P1_Valid_i) begin
        gnt_p1 = 1'b1;
      end
    end
  end

  assign accept     = gnt_p0 | gnt_p1;
  assign P0_Ready_o = gnt_p0;
  assign P1_Ready_o = gnt_p1;

  // Request mux toward memory; port 0 drives the bus when idle.
  always_comb begin
    sel_we    = P0_We_i;
    sel_addr  = P0_Address_i;
    sel_wdata = P0_Write_Data_i;
    if (gnt_p1) begin
      sel_we    = P1_We_i;
      sel_addr  = P1_Address_i;
      sel_wdata = P1_Write_Data_i;
    end
  end

  data_mem_arbiter_addr_range_check #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .BASE_ADDR    (BASE_ADDR)
  ) u_addr_chk (
    .addr_i (sel_addr),
    .err_o  (sel_err)
  );

  assign Mem_Write_Enable_o = accept & sel_we & ~sel_err;
  assign Mem_Address_o      = sel_addr;
  assign Mem_Write_Data_o   = sel_wdata;

  assign rdata_d = (!sel_we && !sel_err) ? Mem_Read_Data_i : '0;

  // Lock FSM next state. A burst ends on lock release, port-1 idle or after
  // MAX_LOCK contended grants; the return to IDLE with last_grant = P1 is what
  // hands the following contended cycle to port 0.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_p1 && P1_Lock_i) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = P0_Valid_i ? CNT_W'(1) : '0;
          if (lock_cnt_d >= CNT_W'(MAX_LOCK)) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (gnt_p1 && P0_Valid_i) lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!P1_Valid_i || !P1_Lock_i || lock_cnt_d >= CNT_W'(MAX_LOCK)) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state: FSM, burst counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_cnt_q   <= '0;
      last_grant_q <= P1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      if (accept) last_grant_q <= gnt_p1 ? P1 : P0;
    end
  end

  // Per-port response registers; read data holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_vld_q <= '0;
      err_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      resp_vld_q <= {gnt_p1, gnt_p0};
      if (gnt_p0) begin
        err_q[0] <= sel_err;
        rdata0_q <= rdata_d;
      end
      if (gnt_p1) begin
        err_q[1] <= sel_err;
        rdata1_q <= rdata_d;
      end
    end
  end

  assign P0_Resp_Valid_o = resp_vld_q[0];
  assign P1_Resp_Valid_o = resp_vld_q[1];
  assign P0_Err_o        = resp_vld_q[0] & err_q[0];
  assign P1_Err_o        = resp_vld_q[1] & err_q[1];
  assign P0_Read_Data_o  = rdata0_q;
  assign P1_Read_Data_o  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model and memory.
module tb_data_mem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 64;
  localparam int          MAXL  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        P0_Valid_i, P0_We_i, P0_Ready_o, P0_Resp_Valid_o, P0_Err_o;
  logic [31:0] P0_Address_i, P0_Write_Data_i, P0_Read_Data_o;
  logic        P1_Valid_i, P1_We_i, P1_Lock_i, P1_Ready_o, P1_Resp_Valid_o, P1_Err_o;
  logic [31:0] P1_Address_i, P1_Write_Data_i, P1_Read_Data_o;
  logic        Mem_Write_Enable_o;
  logic [31:0] Mem_Address_o, Mem_Write_Data_o, Mem_Read_Data_i;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .P0_Valid_i         (P0_Valid_i),
    .P0_We_i            (P0_We_i),
    .P0_Address_i       (P0_Address_i),
    .P0_Write_Data_i    (P0_Write_Data_i),
    .P0_Ready_o         (P0_Ready_o),
    .P0_Resp_Valid_o    (P0_Resp_Valid_o),
    .P0_Read_Data_o     (P0_Read_Data_o),
    .P0_Err_o           (P0_Err_o),
    .P1_Valid_i         (P1_Valid_i),
    .P1_We_i            (P1_We_i),
    .P1_Address_i       (P1_Address_i),
    .P1_Write_Data_i    (P1_Write_Data_i),
    .P1_Lock_i          (P1_Lock_i),
    .P1_Ready_o         (P1_Ready_o),
    .P1_Resp_Valid_o    (P1_Resp_Valid_o),
    .P1_Read_Data_o     (P1_Read_Data_o),
    .P1_Err_o           (P1_Err_o),
    .Mem_Write_Enable_o (Mem_Write_Enable_o),
    .Mem_Address_o      (Mem_Address_o),
    .Mem_Write_Data_o   (Mem_Write_Data_o),
    .Mem_Read_Data_i    (Mem_Read_Data_i)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Address rule stated arithmetically on unsigned byte addresses.
  function automatic bit ref_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off / 4 >= DEPTH);
  endfunction

  function automatic logic [5:0] idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return off[5:0];
  endfunction

  // Memory the DUT drives, plus an independent shadow copy for expectations.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  assign Mem_Read_Data_i = ref_err(Mem_Address_o) ? 32'hBAD0_BAD0 : mem[idx_of(Mem_Address_o)];

  always @(posedge clk)
    if (Mem_Write_Enable_o && !ref_err(Mem_Address_o))
      mem[idx_of(Mem_Address_o)] <= Mem_Write_Data_o;

  // Reference model state.
  int          m_last;      // port granted most recently
  bit          m_locked;    // port 1 burst in progress
  int          m_burst;     // contended port-1 grants in this burst
  bit          pend_v [2];
  bit          pend_e [2];
  logic [31:0] exp_rd [2];

  int rr_pat   [4] = '{0, 1, 0, 1};
  int lock_pat [8] = '{0, 1, 1, 1, 1, 0, 1, 1};

  // One clock: inputs already applied; check grant and memory drive, advance
  // the model, then check the registered responses after the edge.
  task automatic step();
    int          g;
    logic [31:0] a, d;
    logic        w, e;
    logic [5:0]  ix;
    #1;
    g = -1;
    if (!reset) begin
      if (P0_Valid_i && P1_Valid_i) g = m_locked ? 1 : 1 - m_last;
      else if (P0_Valid_i)          g = 0;
      else if (P1_Valid_i)          g = 1;
    end
    a  = (g == 1) ? P1_Address_i    : P0_Address_i;
    d  = (g == 1) ? P1_Write_Data_i : P0_Write_Data_i;
    w  = (g == 1) ? P1_We_i         : P0_We_i;
    e  = ref_err(a);
    ix = idx_of(a);
    chk("p0_ready", 32'(P0_Ready_o), 32'(g == 0));
    chk("p1_ready", 32'(P1_Ready_o), 32'(g == 1));
    chk("mem_we", 32'(Mem_Write_Enable_o), 32'(g >= 0 && w && !e));
    if (g >= 0) begin
      chk("mem_addr", Mem_Address_o, a);
      if (w) chk("mem_wdata", Mem_Write_Data_o, d);
    end

    if (reset) begin
      m_last = 1; m_locked = 0; m_burst = 0;
      pend_v = '{0, 0};
      exp_rd = '{32'h0, 32'h0};
    end else begin
      pend_v = '{0, 0};
      if (g >= 0) begin
        pend_v[g] = 1;
        pend_e[g] = e;
        exp_rd[g] = (!w && !e) ? ref_mem[ix] : 32'h0;
        if (w && !e) ref_mem[ix] = d;
        m_last = g;
      end
      if (g == 1 && P0_Valid_i && (m_locked || P1_Lock_i)) m_burst++;
      if (m_locked) begin
        if (!P1_Valid_i || !P1_Lock_i || m_burst >= MAXL) begin
          m_locked = 0; m_burst = 0;
        end
      end else if (g == 1 && P1_Lock_i) begin
        if (m_burst >= MAXL) m_burst = 0;
        else                 m_locked = 1;
      end
    end

    @(posedge clk);
    #1;
    chk("p0_rvld", 32'(P0_Resp_Valid_o), 32'(pend_v[0]));
    chk("p1_rvld", 32'(P1_Resp_Valid_o), 32'(pend_v[1]));
    if (pend_v[0]) chk("p0_err", 32'(P0_Err_o), 32'(pend_e[0]));
    if (pend_v[1]) chk("p1_err", 32'(P1_Err_o), 32'(pend_e[1]));
    chk("p0_rdata", P0_Read_Data_o, exp_rd[0]);
    chk("p1_rdata", P1_Read_Data_o, exp_rd[1]);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return BASE + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
    else if (r == 1) return BASE - 32'(4 * $urandom_range(1, 8));
    else if (r == 2) return BASE + 32'(4 * $urandom_range(64, 70));
    else             return BASE + 32'(4 * $urandom_range(0, 63));
  endfunction

  task automatic set_p0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    P0_Valid_i = v; P0_We_i = we; P0_Address_i = a; P0_Write_Data_i = d;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic lk);
    P1_Valid_i = v; P1_We_i = we; P1_Address_i = a; P1_Write_Data_i = d; P1_Lock_i = lk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
    end
    m_last = 1; m_locked = 0; m_burst = 0;
    pend_v = '{0, 0}; pend_e = '{0, 0};
    exp_rd = '{32'h0, 32'h0};

    // Reset held two cycles with both ports requesting.
    reset = 1'b1;
    set_p0(1'b1, 1'b0, BASE,           32'h0);
    set_p1(1'b1, 1'b1, BASE + 32'd8,   32'h1111_2222, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Round-robin between two readers.
    set_p1(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_seq", 32'(P1_Ready_o), 32'(rr_pat[i]));
      step();
    end

    // Port 1 holds Lock under contention.
    set_p1(1'b1, 1'b0, BASE + 32'd12, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lock_seq", 32'(P1_Ready_o), 32'(lock_pat[i]));
      step();
    end
    set_p1(1'b0, 1'b0, BASE, 32'h0, 1'b0);
    step();

    // Error cases on port 0.
    set_p0(1'b1, 1'b1, 32'h1001_0100, 32'hCAFE_0001);
    step();
    chk("err_word64", 32'(P0_Err_o), 32'd1);
    set_p0(1'b1, 1'b1, 32'h1001_0002, 32'hCAFE_0002);
    step();
    chk("err_misalign", 32'(P0_Err_o), 32'd1);
    set_p0(1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
    step();
    chk("err_below", 32'(P0_Err_o), 32'd1);
    chk("err_rdata", P0_Read_Data_o, 32'h0);

    // Write then read back the last word.
    set_p0(1'b1, 1'b1, 32'h1001_00FC, 32'hDEAD_BEEF);
    step();
    set_p0(1'b1, 1'b0, 32'h1001_00FC, 32'h0);
    step();
    chk("raw_data", P0_Read_Data_o, 32'hDEAD_BEEF);
    chk("raw_err", 32'(P0_Err_o), 32'd0);

    // Reset in the middle of a locked burst.
    set_p0(1'b1, 1'b0, BASE + 32'd16, 32'h0);
    set_p1(1'b1, 1'b0, BASE + 32'd20, 32'h0, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_p0", 32'(P0_Ready_o), 32'd1);
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
      set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
             $urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the processor core data path, port 1 is the loader/DMA engine.
- Arbitrates one access per cycle using round-robin with a bounded burst lock for port 1.
- Range- and alignment-checks every address against the data segment before it reaches the memory.
- Read data is registered and returned one cycle after acceptance.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MEMORY_DEPTH, 64, number of words in the data memory.
- BASE_ADDR, 32'h10010000, byte address of word 0 of the data segment.
- MAX_LOCK, 4, maximum consecutive port-1 grants while Lock is held and port 0 is waiting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- P0_Valid_i  in  1  port 0 request valid.
- P0_We_i  in  1  port 0 write (1) / read (0).
- P0_Address_i  in  DATA_WIDTH  port 0 byte address.
- P0_Write_Data_i  in  DATA_WIDTH  port 0 write data.
- P0_Ready_o  out  1  port 0 request accepted this cycle.
- P0_Resp_Valid_o  out  1  port 0 response valid.
- P0_Read_Data_o  out  DATA_WIDTH  port 0 read data.
- P0_Err_o  out  1  port 0 response is an error.
- P1_Valid_i, P1_We_i, P1_Address_i, P1_Write_Data_i, P1_Ready_o, P1_Resp_Valid_o, P1_Read_Data_o, P1_Err_o  as for port 0.
- P1_Lock_i  in  1  port 1 requests to keep the grant.
- Mem_Write_Enable_o  out  1  to memory write enable.
- Mem_Address_o  out  DATA_WIDTH  to memory byte address.
- Mem_Write_Data_o  out  DATA_WIDTH  to memory write data.
- Mem_Read_Data_i  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - All Resp_Valid_o, Err_o and Read_Data_o are 0.
  - last_grant = 1, so port 0 wins first.
  - lock_cnt = 0 and FSM = IDLE.
  - Any transaction accepted in the reset cycle is discarded: no response and no write.
- Grant is combinational within the cycle. Ready_o of the granted port is 1, the other is 0. A request is accepted when Valid & Ready.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: the port opposite last_grant wins, unless the LOCKED override applies.
  - last_grant updates on every accepted request.
- FSM:
  - IDLE -> LOCKED when port 1 is accepted with P1_Lock_i = 1.
  - In LOCKED, port 1 keeps priority over port 0 and lock_cnt increments on each port-1 grant made while port 0 is valid.
  - LOCKED -> IDLE when P1_Lock_i = 0, when P1_Valid_i = 0, or when lock_cnt reaches MAX_LOCK. In the MAX_LOCK case port 0 is forced to be granted in the next cycle.
  - lock_cnt clears on entry to IDLE.
- Address check:
  - Offset = addr - BASE_ADDR, modulo 2^32.
  - Error if addr[1:0] != 0 or (offset >> 2) >= MEMORY_DEPTH. Addresses below BASE_ADDR wrap to large offsets and are therefore errors.
- Memory drive in an accept cycle:
  - Mem_Address_o = granted address.
  - Mem_Write_Data_o = granted write data.
  - Mem_Write_Enable_o = We & ~error.
- Memory drive with no accept: Mem_Write_Enable_o = 0. Address and data hold the port-0 inputs, which are don't-care.
- Response latency is exactly 1 cycle. The cycle after acceptance, the accepting port has:
  - Resp_Valid_o = 1 for one cycle.
  - Err_o = error flag.
  - Read_Data_o = registered Mem_Read_Data_i for a valid read, else 0. Writes return 0.
- Read_Data_o holds its value when Resp_Valid_o = 0.
- Back-to-back: one acceptance per cycle is sustained indefinitely.
- Read-after-write: a same-port read issued the cycle after a write to the same address returns the new data, because the memory writes on the edge and reads combinationally.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, LOCKED).
  - BASE_ADDR default.
  - Port index constants P0 = 0, P1 = 1.
  - Address-check function.
- One natural sub-module: addr_range_check (combinational offset/alignment/range check). It is instantiated twice, once per port, or once on the muxed address.

Test Plan:
- Reset: assert reset for 2 cycles with both ports valid -> no Ready, no Resp_Valid, Mem_Write_Enable_o = 0. First grant after reset goes to port 0.
- Round-robin: both ports valid for 4 cycles, reading 0x10010000 and 0x10010004 -> grants alternate P0, P1, P0, P1. Each Resp_Valid arrives 1 cycle later with the correct data.
- Burst lock, MAX_LOCK = 4: P1 holds Lock with both ports valid -> four P1 grants, then one forced P0 grant, then P1 again.
- Errors, each answered with Err_o = 1 the next cycle, Read_Data_o = 0 and Mem_Write_Enable_o = 0:
  - Write to 0x10010100 (word 64).
  - Write to 0x10010002 (misaligned).
  - Read at 0x1000FFFC (below base).
- Write-then-read: P0 writes 0xDEADBEEF to 0x100100FC, then reads it the next cycle -> P0_Read_Data_o = 0xDEADBEEF, Err_o = 0.
- Reset mid-lock: assert reset during LOCKED -> FSM returns to IDLE with lock_cnt = 0. The pending response is suppressed, and the next contended grant goes to port 0.
